// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode and timing controller for the stopwatch timer.
// Synchronizes ADJ/SEL/PAUSE, debounces PAUSE, runs the RUN/PAUSE/ADJUST
// state machine and produces single-cycle increment strobes, adjust-mode
// blink blanking and the 7-segment digit-scan select. Single clock domain.
//
// Ports:
//   clk        master clock
//   RESET      synchronous, active-high reset
//   ADJ        raw adjust switch (async)
//   SEL        raw select switch (async), 0 = minutes, 1 = seconds
//   PAUSE      raw pause button (async, bouncy)
//   inc_sec    one-cycle seconds-increment strobe
//   inc_min    one-cycle minutes-increment strobe
//   blank_sec  blank seconds digits (adjust blink)
//   blank_min  blank minutes digits (adjust blink)
//   scan_sel   active digit index
//   mode       00 RUN, 01 PAUSE, 10 ADJUST
//   paused     high in PAUSE, or in ADJUST when returning to PAUSE
module stopwatch_ctrl #(
  parameter int DIV_1HZ   = 100000000,
  parameter int DIV_2HZ   = 50000000,
  parameter int DIV_BLINK = 25000000,
  parameter int DIV_SCAN  = 100000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       ADJ,
  input  logic       SEL,
  input  logic       PAUSE,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       blank_sec,
  output logic       blank_min,
  output logic [1:0] scan_sel,
  output logic [1:0] mode,
  output logic       paused
);

  localparam logic [1:0] MODE_RUN    = 2'b00;
  localparam logic [1:0] MODE_PAUSE  = 2'b01;
  localparam logic [1:0] MODE_ADJUST = 2'b10;

  localparam int RUN_W   = (DIV_1HZ   > 1) ? $clog2(DIV_1HZ)   : 1;
  localparam int ADJ_W   = (DIV_2HZ   > 1) ? $clog2(DIV_2HZ)   : 1;
  localparam int BLINK_W = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;
  localparam int SCAN_W  = (DIV_SCAN  > 1) ? $clog2(DIV_SCAN)  : 1;
  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [RUN_W-1:0]   RUN_TERM   = RUN_W'(DIV_1HZ - 1);
  localparam logic [ADJ_W-1:0]   ADJ_TERM   = ADJ_W'(DIV_2HZ - 1);
  localparam logic [BLINK_W-1:0] BLINK_TERM = BLINK_W'(DIV_BLINK - 1);
  localparam logic [SCAN_W-1:0]  SCAN_TERM  = SCAN_W'(DIV_SCAN - 1);
  localparam logic [DB_W-1:0]    DB_TERM    = DB_W'(DB_CYCLES - 1);

  // ---------------- two-flop synchronizers: bit 0 ADJ, 1 SEL, 2 PAUSE
  logic [2:0] raw_in;
  logic [2:0] sync_s2;
  assign raw_in = {PAUSE, SEL, ADJ};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk) begin
        if (RESET) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_s2[gi] = s2_reg;
    end
  endgenerate

  logic adj_s2, sel_s2, pause_s2;
  assign adj_s2   = sync_s2[0];
  assign sel_s2   = sync_s2[1];
  assign pause_s2 = sync_s2[2];

  // ---------------- PAUSE debounce: accept a level only after it has
  // differed from the current level for DB_CYCLES consecutive samples
  logic            db_level_reg;
  logic            db_prev_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            press;

  always_ff @(posedge clk) begin
    if (RESET) begin
      db_level_reg <= 1'b0;
      db_prev_reg  <= 1'b0;
      db_cnt_reg   <= '0;
    end else begin
      db_prev_reg <= db_level_reg;
      if (pause_s2 == db_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_TERM) begin
        db_level_reg <= pause_s2;
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end
  end

  assign press = db_level_reg & ~db_prev_reg;

  // ---------------- mode FSM: state register
  logic [1:0] mode_reg, mode_next;
  logic [1:0] ret_reg, ret_next;

  always_ff @(posedge clk) begin
    if (RESET) begin
      mode_reg <= MODE_RUN;
      ret_reg  <= MODE_RUN;
    end else begin
      mode_reg <= mode_next;
      ret_reg  <= ret_next;
    end
  end

  // ---------------- mode FSM: next state (ADJ has priority over presses)
  always_comb begin
    mode_next = mode_reg;
    ret_next  = ret_reg;
    if (adj_s2 && (mode_reg != MODE_ADJUST)) begin
      mode_next = MODE_ADJUST;
      ret_next  = mode_reg;
    end else if (mode_reg == MODE_ADJUST) begin
      if (!adj_s2) begin
        mode_next = ret_reg;
      end
    end else if (press) begin
      mode_next = (mode_reg == MODE_RUN) ? MODE_PAUSE : MODE_RUN;
    end
  end

  // Prescalers only advance when the mode is kept across the edge, so no
  // strobe can land in the first cycle of a different mode.
  logic stay_run, stay_adj, enter_adj;
  assign stay_run  = (mode_reg == MODE_RUN)    && (mode_next == MODE_RUN);
  assign stay_adj  = (mode_reg == MODE_ADJUST) && (mode_next == MODE_ADJUST);
  assign enter_adj = (mode_reg != MODE_ADJUST) && (mode_next == MODE_ADJUST);

  // ---------------- run prescaler: holds in PAUSE, cleared on ADJUST entry
  logic [RUN_W-1:0] run_cnt_reg;
  logic             run_tick;
  assign run_tick = stay_run && (run_cnt_reg == RUN_TERM);

  always_ff @(posedge clk) begin
    if (RESET || enter_adj) begin
      run_cnt_reg <= '0;
    end else if (stay_run) begin
      run_cnt_reg <= run_tick ? '0 : run_cnt_reg + RUN_W'(1);
    end
  end

  // ---------------- adjust prescaler and blink phase, live only in ADJUST
  logic [ADJ_W-1:0]   adj_cnt_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_dark_reg;
  logic               adj_tick;
  assign adj_tick = stay_adj && (adj_cnt_reg == ADJ_TERM);

  always_ff @(posedge clk) begin
    if (RESET || !stay_adj) begin
      adj_cnt_reg    <= '0;
      blink_cnt_reg  <= '0;
      blink_dark_reg <= 1'b0;
    end else begin
      adj_cnt_reg <= adj_tick ? '0 : adj_cnt_reg + ADJ_W'(1);
      if (blink_cnt_reg == BLINK_TERM) begin
        blink_cnt_reg  <= '0;
        blink_dark_reg <= ~blink_dark_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

  // ---------------- strobes (run_tick and adj_tick are mutually exclusive)
  logic inc_sec_reg, inc_min_reg;
  always_ff @(posedge clk) begin
    if (RESET) begin
      inc_sec_reg <= 1'b0;
      inc_min_reg <= 1'b0;
    end else begin
      inc_sec_reg <= run_tick | (adj_tick & sel_s2);
      inc_min_reg <= adj_tick & ~sel_s2;
    end
  end

  // ---------------- digit scan, free-running in every mode
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [1:0]        scan_sel_reg;
  always_ff @(posedge clk) begin
    if (RESET) begin
      scan_cnt_reg <= '0;
      scan_sel_reg <= 2'd0;
    end else if (scan_cnt_reg == SCAN_TERM) begin
      scan_cnt_reg <= '0;
      scan_sel_reg <= scan_sel_reg + 2'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  // ---------------- mode FSM: outputs
  always_comb begin
    mode      = mode_reg;
    paused    = (mode_reg == MODE_PAUSE) ||
                ((mode_reg == MODE_ADJUST) && (ret_reg == MODE_PAUSE));
    blank_sec = (mode_reg == MODE_ADJUST) &&  sel_s2 && blink_dark_reg;
    blank_min = (mode_reg == MODE_ADJUST) && !sel_s2 && blink_dark_reg;
  end

  assign inc_sec  = inc_sec_reg;
  assign inc_min  = inc_min_reg;
  assign scan_sel = scan_sel_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against an arithmetic reference model.
module tb_stopwatch_ctrl;

  localparam int P_1HZ   = 10;
  localparam int P_2HZ   = 5;
  localparam int P_BLINK = 3;
  localparam int P_SCAN  = 4;
  localparam int P_DB    = 4;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       ADJ = 1'b0;
  logic       SEL = 1'b0;
  logic       PAUSE = 1'b0;
  logic       inc_sec, inc_min, blank_sec, blank_min, paused;
  logic [1:0] scan_sel, mode;

  stopwatch_ctrl #(
    .DIV_1HZ(P_1HZ), .DIV_2HZ(P_2HZ), .DIV_BLINK(P_BLINK),
    .DIV_SCAN(P_SCAN), .DB_CYCLES(P_DB)
  ) dut (
    .clk(clk), .RESET(RESET), .ADJ(ADJ), .SEL(SEL), .PAUSE(PAUSE),
    .inc_sec(inc_sec), .inc_min(inc_min),
    .blank_sec(blank_sec), .blank_min(blank_min),
    .scan_sel(scan_sel), .mode(mode), .paused(paused)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (modes 0 RUN, 1 PAUSE, 2 ADJUST)
  int m_cyc = 0;        // edges since reset released
  int m_run_el = 0;     // RUN cycles counted since last clear
  int m_age = 0;        // edges spent in ADJUST since entry
  int m_mode = 0;
  int m_ret = 0;
  int m_db_run = 0;     // consecutive samples differing from accepted level
  bit m_db_level = 0;
  bit m_rose = 0;
  bit m_inc_sec = 0;
  bit m_inc_min = 0;
  bit m_s1[3] = '{0, 0, 0};  // 0 ADJ, 1 SEL, 2 PAUSE
  bit m_s2[3] = '{0, 0, 0};

  task automatic model_edge();
    int nm;
    bit adj, sel, pz, new_level;
    if (RESET) begin
      m_cyc = 0; m_run_el = 0; m_age = 0; m_mode = 0; m_ret = 0;
      m_db_run = 0; m_db_level = 0; m_rose = 0;
      m_inc_sec = 0; m_inc_min = 0;
      for (int i = 0; i < 3; i++) begin m_s1[i] = 0; m_s2[i] = 0; end
      return;
    end
    adj = m_s2[0]; sel = m_s2[1]; pz = m_s2[2];
    if (adj && m_mode != 2)   nm = 2;
    else if (m_mode == 2)     nm = adj ? 2 : m_ret;
    else if (m_rose)          nm = (m_mode == 0) ? 1 : 0;
    else                      nm = m_mode;

    m_inc_sec = 0; m_inc_min = 0;
    if (m_mode == 0 && nm == 0) begin
      m_run_el++;
      if (m_run_el % P_1HZ == 0) m_inc_sec = 1;
    end else if (nm == 2 && m_mode != 2) begin
      m_run_el = 0;
    end
    if (nm == 2 && m_mode == 2) begin
      m_age++;
      if (m_age % P_2HZ == 0) begin
        if (sel) m_inc_sec = 1; else m_inc_min = 1;
      end
    end else begin
      m_age = 0;
    end

    new_level = m_db_level;
    if (pz == m_db_level) m_db_run = 0;
    else if (m_db_run == P_DB - 1) begin new_level = pz; m_db_run = 0; end
    else m_db_run++;
    m_rose = new_level & ~m_db_level;
    m_db_level = new_level;

    for (int i = 0; i < 3; i++) m_s2[i] = m_s1[i];
    m_s1[0] = ADJ; m_s1[1] = SEL; m_s1[2] = PAUSE;

    if (adj && m_mode != 2) m_ret = m_mode;
    m_mode = nm;
    m_cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // ---------------- per-cycle compare
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      logic [8:0] dv, ev;
      bit dark, exp_paused;
      dark = (m_mode == 2) && (((m_age / P_BLINK) % 2) == 1);
      exp_paused = (m_mode == 1) || (m_mode == 2 && m_ret == 1);
      ev = {m_inc_sec, m_inc_min, dark & m_s2[1], dark & ~m_s2[1],
            2'((m_cyc / P_SCAN) % 4), 2'(m_mode), exp_paused};
      dv = {inc_sec, inc_min, blank_sec, blank_min, scan_sel, mode, paused};
      check("cycle{isec,imin,bsec,bmin,scan,mode,paused}", int'(dv), int'(ev));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus
  initial begin
    int hold;
    cyc(3);
    check_en = 1'b1;
    RESET = 1'b0;

    // 1: free-run tick cadence and scan
    cyc(9);  check("t1_no_tick_at_9", inc_sec, 0);
    cyc(1);  check("t1_tick_at_10", inc_sec, 1);
    check("t1_scan_at_10", scan_sel, 2);
    check("t1_inc_min", inc_min, 0);

    // 2: press at run-count 6, resume 4 cycles before next tick
    PAUSE = 1'b1;
    cyc(6);  check("t2_mode_before", mode, 0);
    cyc(1);  check("t2_mode_paused", mode, 1);
    check("t2_paused_flag", paused, 1);
    cyc(3);  PAUSE = 1'b0;
    cyc(20); check("t2_still_paused", mode, 1);
    PAUSE = 1'b1;
    cyc(7);  check("t2_resumed", mode, 0);
    cyc(3);  check("t2_no_tick_early", inc_sec, 0);
    cyc(1);  check("t2_tick_after_4", inc_sec, 1);
    PAUSE = 1'b0;
    cyc(12);

    // 3: short glitch rejected
    PAUSE = 1'b1; cyc(3); PAUSE = 1'b0;
    cyc(10); check("t3_glitch_mode", mode, 0);

    // 4: adjust minutes, then seconds
    ADJ = 1'b1; SEL = 1'b0;
    cyc(3);  check("t4_mode_adjust", mode, 2);
    check("t4_blank_visible", blank_min, 0);
    cyc(3);  check("t4_blank_dark", blank_min, 1);
    cyc(2);  check("t4_inc_min", inc_min, 1);
    check("t4_no_inc_sec", inc_sec, 0);
    SEL = 1'b1;
    cyc(5);  check("t4_inc_sec_after_sel", inc_sec, 1);
    check("t4_no_inc_min", inc_min, 0);
    check("t4_blank_sec", blank_sec, 1);
    check("t4_blank_min_off", blank_min, 0);
    ADJ = 1'b0;
    cyc(3);  check("t4_back_to_run", mode, 0);
    cyc(5);

    // 5: adjust from pause, press ignored, return to pause
    PAUSE = 1'b1; cyc(7); check("t5_paused", mode, 1);
    PAUSE = 1'b0; cyc(8);
    ADJ = 1'b1;   cyc(3); check("t5_adjust", mode, 2);
    check("t5_paused_in_adj", paused, 1);
    PAUSE = 1'b1; cyc(8); PAUSE = 1'b0; cyc(8);
    check("t5_press_ignored", mode, 2);
    ADJ = 1'b0;   cyc(3); check("t5_return_pause", mode, 1);
    check("t5_paused_after", paused, 1);
    PAUSE = 1'b1; cyc(7); check("t5_run_again", mode, 0);
    PAUSE = 1'b0; cyc(8);

    // 6: reset mid-adjust
    ADJ = 1'b1; cyc(7);
    RESET = 1'b1; ADJ = 1'b0;
    cyc(1);  check("t6_mode_reset", mode, 0);
    check("t6_scan_reset", scan_sel, 0);
    check("t6_strobes_reset", {inc_sec, inc_min, blank_sec, blank_min}, 0);
    RESET = 1'b0;
    cyc(9);  check("t6_no_tick_9", inc_sec, 0);
    cyc(1);  check("t6_tick_10", inc_sec, 1);

    // randomized phase
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) ADJ = ~ADJ;
      if ($urandom_range(0, 59) == 0)  SEL = ~SEL;
      if (hold == 0) begin
        PAUSE = ~PAUSE;
        hold = (PAUSE == 1'b0 && $urandom_range(0, 3) != 0) ?
               $urandom_range(10, 40) : $urandom_range(1, 8);
      end else begin
        hold--;
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode and timing controller for the stopwatch timer. It synchronizes the ADJ and SEL switches and the PAUSE button, and debounces PAUSE. A RUN/PAUSE/ADJUST state machine produces single-cycle increment strobes (seconds at 1 Hz in RUN; the selected field at 2 Hz in ADJUST). It also generates the adjust-mode blink blanking and the 7-segment digit-scan select. All logic runs on the master clock; no derived clocks are produced.

Parameters:
DIV_1HZ, 100000000, clk cycles per run tick
DIV_2HZ, 50000000, clk cycles per adjust tick
DIV_BLINK, 25000000, clk cycles per blink phase
DIV_SCAN, 100000, clk cycles per scan-select step
DB_CYCLES, 1000000, consecutive stable synced samples needed to accept a PAUSE level change

Ports:
clk  in  1  master clock
RESET  in  1  synchronous, active-high reset (already conditioned upstream)
ADJ  in  1  raw adjust switch (async)
SEL  in  1  raw select switch (async); 0 = minutes, 1 = seconds
PAUSE  in  1  raw pause button (async, bouncy)
inc_sec  out  1  one-cycle seconds-increment strobe
inc_min  out  1  one-cycle minutes-increment strobe
blank_sec  out  1  blank seconds digits
blank_min  out  1  blank minutes digits
scan_sel  out  2  active digit index
mode  out  2  00 RUN, 01 PAUSE, 10 ADJUST
paused  out  1  high in PAUSE, or in ADJUST with return target PAUSE

Behaviour:
- Interface: reset RESET, synchronous, active-high; clock clk. All state is registered on posedge clk.
- On RESET, every register clears:
  - mode=RUN, ret=RUN, paused=0
  - inc_sec=0, inc_min=0, blank_sec=0, blank_min=0, scan_sel=0
  - all prescalers=0, sync flops=0, db_level=0, db_prev=0
- Synchronizers: ADJ, SEL and PAUSE each pass through 2 flops (s1, s2). All logic uses s2 only.
- Debounce:
  - db_cnt clears whenever s2==db_level.
  - While s2!=db_level: if db_cnt==DB_CYCLES-1, then db_level<=s2 and db_cnt<=0; otherwise db_cnt increments.
  - press = db_level & ~db_prev, where db_prev is db_level delayed one cycle.
  - Timing: if the first edge sampling raw PAUSE high is edge k, db_level rises at edge k+1+DB_CYCLES and mode changes at edge k+2+DB_CYCLES.
  - Pulses shorter than DB_CYCLES synced cycles are rejected.
- FSM, evaluated in priority order each cycle:
  - ADJ==1 and mode!=ADJUST: mode<=ADJUST; ret<=current mode. A press in the same cycle is discarded.
  - ADJUST and ADJ==0: mode<=ret.
  - ADJUST: presses ignored.
  - RUN + press: go to PAUSE.
  - PAUSE + press: go to RUN.
- Run prescaler (0..DIV_1HZ-1):
  - Counts only in RUN and holds in PAUSE, so a partial second resumes.
  - Clears on entry to ADJUST.
  - At terminal count it wraps to 0 and inc_sec<=1 for exactly one cycle.
  - First tick after reset arrives DIV_1HZ cycles after reset deasserts; period is exactly DIV_1HZ.
- Adjust prescaler (0..DIV_2HZ-1):
  - Counts only in ADJUST; cleared otherwise.
  - At terminal count: inc_sec<=1 if SEL(s2)==1, else inc_min<=1.
  - First adjust strobe arrives DIV_2HZ cycles after ADJUST entry.
  - SEL changes take effect on the next strobe.
- Strobe exclusivity: inc_sec and inc_min are never high simultaneously. Neither is ever high in PAUSE.
- Blink:
  - In ADJUST, phase toggles every DIV_BLINK cycles, starting visible (phase=1) on entry.
  - blank_sec = ADJUST & SEL & ~phase; blank_min = ADJUST & ~SEL & ~phase.
  - Outside ADJUST both are 0 and the blink counter is held at 0.
- Scan: scan_sel increments mod 4 every DIV_SCAN cycles in all modes, wrapping 3->0.
- Reset mid-operation: all outputs are restored to reset values on the next edge, including any strobe in flight and partially debounced presses.

Test Plan:
All scenarios use parameters DIV_1HZ=10, DIV_2HZ=5, DIV_BLINK=3, DIV_SCAN=4, DB_CYCLES=4.
1. Release RESET, idle -> inc_sec pulses 1 cycle wide at cycles 10, 20, 30; inc_min stays 0; scan_sel steps every 4 cycles 0,1,2,3,0.
2. Hold PAUSE high 10 cycles at run-count 6 -> mode=01 at edge k+6; no inc_sec while paused; second press -> RUN, next inc_sec 4 cycles after resume.
3. PAUSE glitch high 3 cycles -> db_level stays 0; mode stays RUN; strobe cadence unchanged.
4. ADJ=1, SEL=0 -> mode=10; inc_min every 5 cycles, inc_sec=0; blank_min pattern 0,0,0,1,1,1 repeating. Flip SEL=1 -> next strobe is inc_sec, blanking moves to blank_sec.
5. Enter ADJUST from PAUSE, press PAUSE during ADJUST, then drop ADJ -> press ignored, mode returns to 01, paused=1 throughout.
6. RESET asserted in ADJUST mid-count -> next edge: mode=00, all strobes/blanks 0, scan_sel=0; first inc_sec 10 cycles after release.
